uart_tx: RTL and testbench

- Serial UART transmitter: the transmit side of the UART pair, complementing the SerDataIn/PalDataOut receiver.
- Accepts 8-bit parallel words over a permit/enable handshake and emits 8N1 frames on SerDataOut.
- Parity is optional.
- One-word holding register plus shift register allows back-to-back frames with no idle gap.
- System clock: 12.288 MHz; line rate: 256000 bps (48 clocks/bit).

---
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-word holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (PARITY_ODD selects odd parity).
module uart_tx #(
    parameter int CLKS_PER_BIT = 48,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       Clk,
    input  logic       Rstn,
    input  logic [7:0] PalDataIn,
    input  logic       PalDataInEn,
    output logic       PalDataInPermit,
    output logic       SerDataOut,
    output logic       TxBusy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParam
        $error("uart_tx: illegal parameter value");
    end

    stateT       state;
    logic [7:0]  holdReg;
    logic [7:0]  shiftReg;
    logic [15:0] baudCnt;
    logic [2:0]  bitIdx;
    logic        stopCnt;
    logic        bitEnd;
    logic        lastStop;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        parityBit;
`endif

    assign bitEnd   = baudCnt == LAST;
    assign lastStop = stopCnt == 1'(STOP_BITS - 1);
    // A full holding register is picked up from IDLE or on the last STOP cycle, giving zero idle gap.
    assign load     = !PalDataInPermit && (state == IDLE || (state == STOP && bitEnd && lastStop));

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state           <= IDLE;
            holdReg         <= '0;
            shiftReg        <= '0;
            baudCnt         <= '0;
            bitIdx          <= '0;
            stopCnt         <= 1'b0;
            PalDataInPermit <= 1'b1;
            SerDataOut      <= 1'b1;
            TxBusy          <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit       <= 1'b0;
`endif
        end else begin
            if (PalDataInEn && PalDataInPermit) begin
                holdReg         <= PalDataIn;
                PalDataInPermit <= 1'b0;
            end
            baudCnt <= (state == IDLE || bitEnd) ? '0 : baudCnt + 1'b1;
            if (load) begin
                shiftReg        <= holdReg;
                PalDataInPermit <= 1'b1;
                state           <= START;
                SerDataOut      <= 1'b0;
                TxBusy          <= 1'b1;
                bitIdx          <= '0;
                stopCnt         <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parityBit       <= ^holdReg ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    IDLE: SerDataOut <= 1'b1;
                    START: if (bitEnd) begin
                        state      <= DATA;
                        SerDataOut <= shiftReg[0];
                    end
                    DATA: if (bitEnd) begin
                        shiftReg <= shiftReg >> 1;
                        bitIdx   <= bitIdx + 1'b1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            SerDataOut <= parityBit;
`else
                            state      <= STOP;
                            SerDataOut <= 1'b1;
`endif
                        end else begin
                            SerDataOut <= shiftReg[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: if (bitEnd) begin
                        state      <= STOP;
                        SerDataOut <= 1'b1;
                    end
`endif
                    STOP: if (bitEnd) begin
                        if (!lastStop) begin
                            stopCnt <= stopCnt + 1'b1;
                        end else begin
                            stopCnt    <= 1'b0;
                            state      <= IDLE;
                            TxBusy     <= 1'b0;
                            SerDataOut <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, handshake, back-to-back and reset behaviour.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       Clk = 1'b0;
    logic       Rstn = 1'b0;
    logic [7:0] PalDataIn = 8'h00;
    logic [2:0] en = 3'b000;
    logic [2:0] permit;
    logic [2:0] ser;
    logic [2:0] busy;
    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    uart_tx dutA (
        .Clk(Clk), .Rstn(Rstn), .PalDataIn(PalDataIn), .PalDataInEn(en[0]),
        .PalDataInPermit(permit[0]), .SerDataOut(ser[0]), .TxBusy(busy[0])
    );
    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dutB (
        .Clk(Clk), .Rstn(Rstn), .PalDataIn(PalDataIn), .PalDataInEn(en[1]),
        .PalDataInPermit(permit[1]), .SerDataOut(ser[1]), .TxBusy(busy[1])
    );
    uart_tx #(.PARITY_ODD(1)) dutC (
        .Clk(Clk), .Rstn(Rstn), .PalDataIn(PalDataIn), .PalDataInEn(en[2]),
        .PalDataInPermit(permit[2]), .SerDataOut(ser[2]), .TxBusy(busy[2])
    );

    // Line level of bit slot i of a frame: start, 8 data LSB first, optional parity, stop(s).
    function automatic logic expBit(input logic [7:0] w, input int i, input logic par);
        if (i == 0) return 1'b0;
        if (i <= 8) return w[i-1];
        if (P == 1 && i == 9) return par;
        return 1'b1;
    endfunction

    task automatic test_reset;
        Rstn = 1'b0;
        repeat (3) @(negedge Clk);
        total++;
        if (ser !== 3'b111 || permit !== 3'b111 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset: ser=%b permit=%b busy=%b, wanted 111 111 000", ser, permit, busy);
        end
        Rstn = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if (ser !== 3'b111 || permit !== 3'b111 || busy !== 3'b000) begin
            bad++;
            $display("FAIL post_reset_idle: ser=%b permit=%b busy=%b, wanted 111 111 000", ser, permit, busy);
        end
    endtask

    task automatic test_frame(input int sel, input logic [7:0] w, input logic par, input string name);
        int cpb;
        int nb;
        logic e;
        cpb = (sel == 1) ? 4 : 48;
        nb  = 10 + P + ((sel == 1) ? 1 : 0);
        @(negedge Clk);
        PalDataIn = w;
        en[sel] = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        en[sel] = 1'b0;
        total++;
        if (permit[sel] !== 1'b0 || ser[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: permit=%b ser=%b busy=%b, wanted 0 1 0", name, permit[sel], ser[sel], busy[sel]);
        end
        for (int k = 1; k <= nb * cpb; k++) begin
            @(negedge Clk);
            e = expBit(w, (k - 1) / cpb, par);
            total++;
            if (ser[sel] !== e || busy[sel] !== 1'b1) begin
                bad++;
                $display("FAIL %s cycle %0d: ser=%b busy=%b, wanted ser=%b busy=1", name, k, ser[sel], busy[sel], e);
            end
            if (k == 1) begin
                total++;
                if (permit[sel] !== 1'b1) begin
                    bad++;
                    $display("FAIL %s permit_return: permit=%b, wanted 1", name, permit[sel]);
                end
            end
        end
        @(negedge Clk);
        total++;
        if (ser[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
            bad++;
            $display("FAIL %s end: ser=%b busy=%b, wanted ser=1 busy=0", name, ser[sel], busy[sel]);
        end
    endtask

    task automatic test_back_to_back;
        int fl;
        logic [7:0] w;
        logic e;
        fl = (10 + P) * 48;
        @(negedge Clk);
        PalDataIn = 8'hA5;
        en[0] = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        en[0] = 1'b0;
        for (int k = 1; k <= 2 * fl; k++) begin
            @(negedge Clk);
            w = ((k - 1) / fl == 0) ? 8'hA5 : 8'h3C;
            e = expBit(w, ((k - 1) % fl) / 48, 1'b0);
            total++;
            if (ser[0] !== e || busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL b2b cycle %0d: ser=%b busy=%b, wanted ser=%b busy=1", k, ser[0], busy[0], e);
            end
            if (k == 1 || k == fl + 1) begin
                total++;
                if (permit[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b permit_high cycle %0d: permit=%b, wanted 1", k, permit[0]);
                end
            end
            if (k == 2 || k == 101) begin
                total++;
                if (permit[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b permit_low cycle %0d: permit=%b, wanted 0", k, permit[0]);
                end
            end
            if (k == 1) begin
                PalDataIn = 8'h3C;
                en[0] = 1'b1;
            end else if (k == 100) begin
                PalDataIn = 8'hFF;
                en[0] = 1'b1;
            end else begin
                en[0] = 1'b0;
            end
        end
        @(negedge Clk);
        total++;
        if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || permit[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b end: ser=%b busy=%b permit=%b, wanted 1 0 1", ser[0], busy[0], permit[0]);
        end
        PalDataIn = 8'h00;
    endtask

    task automatic test_reset_mid;
        @(negedge Clk);
        PalDataIn = 8'h00;
        en[0] = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        en[0] = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            PalDataIn = 8'hFF;
            en[0] = (k == 1);
        end
        total++;
        if (ser[0] !== 1'b0 || permit[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_setup: ser=%b permit=%b, wanted ser=0 permit=0", ser[0], permit[0]);
        end
        #2 Rstn = 1'b0;
        #1;
        total++;
        if (ser[0] !== 1'b1 || permit[0] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: ser=%b permit=%b busy=%b, wanted 1 1 0", ser[0], permit[0], busy[0]);
        end
        @(negedge Clk);
        Rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            total++;
            if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || permit[0] !== 1'b1) begin
                bad++;
                $display("FAIL mid_release %0d: ser=%b busy=%b permit=%b, wanted 1 0 1", k, ser[0], busy[0], permit[0]);
            end
        end
        test_frame(0, 8'h81, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset;
        test_frame(0, 8'h55, 1'b0, "tx55");
`ifdef UART_TX_PARITY_EN
        test_frame(0, 8'h07, 1'b1, "par07_even");
        test_frame(0, 8'h55, 1'b0, "par55_even");
        test_frame(2, 8'h55, 1'b1, "par55_odd");
`endif
        test_back_to_back;
        test_reset_mid;
        test_frame(1, 8'hF0, 1'b0, "stop2_cpb4");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
